// File: rtl/sentinel_key_conditioner_if.sv
// rtl/sentinel_key_conditioner_if.sv - key conditioner handshake bundle
// master drives enable and raw key lines; slave is the conditioner itself.
interface sentinel_key_conditioner_if;
  logic       ena;
  logic [7:0] key_raw;
  logic [7:0] key_stable;
  logic       key_valid;
  logic       key_new;
  logic       auth_ok;
  logic       lockout;
  logic [3:0] fail_count;

  modport master (
    output ena, key_raw,
    input  key_stable, key_valid, key_new, auth_ok, lockout, fail_count
  );

  modport slave (
    input  ena, key_raw,
    output key_stable, key_valid, key_new, auth_ok, lockout, fail_count
  );
endinterface

// File: rtl/sentinel_key_conditioner.sv
// rtl/sentinel_key_conditioner.sv - DIP key synchroniser, debouncer and attempt policing
// Optional timed lockout after repeated failures: define SENTINEL_LOCKOUT_EN.
module sentinel_key_conditioner #(
  parameter logic [7:0]  KEY_VALUE    = 8'hB6,
  parameter int unsigned DEBOUNCE_CYC = 1000,
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned LOCKOUT_CYC  = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sentinel_key_conditioner_if.slave   bus
);

  localparam logic [15:0] DB_MAX   = 16'(DEBOUNCE_CYC);
  localparam logic [3:0]  FAIL_MAX = 4'(MAX_FAILS);

`ifdef SENTINEL_LOCKOUT_EN
  localparam logic [23:0] LOCK_LOAD = 24'(LOCKOUT_CYC - 1);
  typedef enum logic [1:0] {ARMED, GRANTED, LOCKOUT} state_e;
  logic [23:0] lock_tmr_q, lock_tmr_d;
`else
  typedef enum logic [1:0] {ARMED, GRANTED} state_e;
`endif

  logic [7:0]  s1_q, s2_q;
  logic [7:0]  cand_q, cand_d;
  logic [7:0]  stable_q, stable_d;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic        key_new_q, key_new_d;
  logic [3:0]  fail_q, fail_d;
  state_e      state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      db_cnt_q   <= '0;
      key_new_q  <= 1'b0;
      fail_q     <= '0;
      state_q    <= ARMED;
`ifdef SENTINEL_LOCKOUT_EN
      lock_tmr_q <= '0;
`endif
    end else begin
      s1_q       <= bus.key_raw;
      s2_q       <= s1_q;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      key_new_q  <= key_new_d;
      fail_q     <= fail_d;
      state_q    <= state_d;
`ifdef SENTINEL_LOCKOUT_EN
      lock_tmr_q <= lock_tmr_d;
`endif
    end
  end

  // A pending commit pulse is held while disabled so the FSM still sees it on resume.
  always_comb begin
    cand_d    = cand_q;
    stable_d  = stable_q;
    db_cnt_d  = db_cnt_q;
    key_new_d = key_new_q;
    if (bus.ena) begin
      key_new_d = 1'b0;
      if (s2_q != cand_q) begin
        cand_d   = s2_q;
        db_cnt_d = '0;
      end else if (db_cnt_q != DB_MAX) begin
        db_cnt_d = db_cnt_q + 16'd1;
        if ((db_cnt_q + 16'd1 == DB_MAX) && (cand_q != stable_q)) begin
          stable_d  = cand_q;
          key_new_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
`ifdef SENTINEL_LOCKOUT_EN
    lock_tmr_d = lock_tmr_q;
`endif
    if (bus.ena) begin
`ifdef SENTINEL_LOCKOUT_EN
      if (state_q == LOCKOUT) begin
        // Exit does not re-evaluate the held key; a fresh commit is needed.
        if (lock_tmr_q == '0) begin
          state_d = ARMED;
          fail_d  = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - 24'd1;
        end
      end else if (key_new_q) begin
        if (stable_q == KEY_VALUE) begin
          state_d = GRANTED;
          fail_d  = '0;
        end else if (fail_q + 4'd1 < FAIL_MAX) begin
          state_d = ARMED;
          fail_d  = fail_q + 4'd1;
        end else begin
          state_d    = LOCKOUT;
          fail_d     = FAIL_MAX;
          lock_tmr_d = LOCK_LOAD;
        end
      end
`else
      if (key_new_q) begin
        if (stable_q == KEY_VALUE) begin
          state_d = GRANTED;
          fail_d  = '0;
        end else begin
          state_d = ARMED;
          fail_d  = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
        end
      end
`endif
    end
  end

  assign bus.key_stable = stable_q;
  assign bus.key_valid  = (db_cnt_q == DB_MAX);
  assign bus.key_new    = key_new_q & bus.ena;
  assign bus.auth_ok    = (state_q == GRANTED) & bus.ena;
  assign bus.fail_count = fail_q;
`ifdef SENTINEL_LOCKOUT_EN
  assign bus.lockout    = (state_q == LOCKOUT);
`else
  assign bus.lockout    = 1'b0;
`endif

endmodule
